// File: rtl/sig_buf_pkg.sv
// Shared constants, enums and decode helpers
// for the display-side signal trace buffer.
package sig_buf_pkg;

  localparam int TRACE_DEPTH = 512;
  localparam int TRACE_AW = 9;
  localparam int SAMPLE_W = 12;

  localparam logic [11:0] ECG_BASE_DEF = 12'h801;
  localparam logic [11:0] EMG_BASE_DEF = 12'hC7F;

  typedef enum logic {
    CLEAR,
    RUN
  } state_e;

  typedef enum logic [1:0] {
    SEL_NONE,
    SEL_ECG,
    SEL_EMG
  } sel_e;

  // Window test done in 13 bits so base+512
  // never wraps around the 12-bit space.
  function automatic logic win_hit(
    input logic [11:0] addr,
    input logic [11:0] base
  );
    logic [12:0] a;
    logic [12:0] b;
    a = {1'b0, addr};
    b = {1'b0, base};
    return (a >= b) && (a < b + 13'd512);
  endfunction

  function automatic logic [TRACE_AW-1:0] win_idx(
    input logic [11:0] addr,
    input logic [11:0] base
  );
    logic [11:0] d;
    d = addr - base;
    return d[TRACE_AW-1:0];
  endfunction

endpackage

// File: rtl/sig_trace_buffer_if.sv
// Sample streams and VGA read port bundle
// of the signal trace buffer.
interface sig_trace_buffer_if;
  import sig_buf_pkg::*;

  logic ecg_valid;
  logic [SAMPLE_W-1:0] ecg_data;
  logic ecg_ready;
  logic emg_valid;
  logic [SAMPLE_W-1:0] emg_data;
  logic emg_ready;
  logic freeze;
  logic [11:0] sig_addr;
  logic [31:0] sig_data;

  modport master (
    output ecg_valid, ecg_data,
    output emg_valid, emg_data,
    output freeze, sig_addr,
    input ecg_ready, emg_ready,
    input sig_data
  );

  modport slave (
    input ecg_valid, ecg_data,
    input emg_valid, emg_data,
    input freeze, sig_addr,
    output ecg_ready, emg_ready,
    output sig_data
  );

endinterface

// File: rtl/trace_ram.sv
// 512x12 simple dual-port trace memory,
// registered read, old data on collision.
module trace_ram
  import sig_buf_pkg::*;
(
  input  logic                clock,
  input  logic                we,
  input  logic [TRACE_AW-1:0] waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [TRACE_AW-1:0] raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [TRACE_DEPTH];

  // Read samples the array before this edge's write lands.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sig_trace_buffer.sv
// ECG/EMG decimating trace store feeding
// the VGA controller, oldest point at index 0.
module sig_trace_buffer
  import sig_buf_pkg::*;
#(
  parameter int DECIM_LOG2 = 2,
  parameter logic [11:0] ECG_BASE = ECG_BASE_DEF,
  parameter logic [11:0] EMG_BASE = EMG_BASE_DEF
) (
  input logic clock,
  input logic reset,
  sig_trace_buffer_if.slave bus
);

  localparam int N = 1 << DECIM_LOG2;
  localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int ACW = SAMPLE_W + DECIM_LOG2;

  state_e state_q;
  state_e state_d;
  logic [TRACE_AW-1:0] clr_q;
  logic clr_we;
  logic run;

  // State register and clear sweep counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= CLEAR;
      clr_q <= '0;
    end else begin
      state_q <= state_d;
      if (clr_we) begin
        clr_q <= clr_q + 1'b1;
      end
    end
  end

  // CLEAR zeroes one entry per cycle, then RUN.
  always_comb begin
    state_d = state_q;
    clr_we = 1'b0;
    run = 1'b0;
    unique case (state_q)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_q == TRACE_AW'(TRACE_DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: run = 1'b1;
      default: state_d = CLEAR;
    endcase
  end

  assign bus.ecg_ready = run;
  assign bus.emg_ready = run;

  logic [ACW-1:0] ecg_acc;
  logic [CW-1:0] ecg_cnt;
  logic [TRACE_AW-1:0] ecg_wr_ptr;
  logic ecg_take;
  logic ecg_last;
  logic ecg_push;
  logic [ACW-1:0] ecg_sum;

  assign ecg_take = bus.ecg_valid & run & ~bus.freeze;
  assign ecg_last = (ecg_cnt == CW'(N - 1));
  assign ecg_push = ecg_take & ecg_last;
  assign ecg_sum = ecg_acc + ACW'(bus.ecg_data);

  // ECG box-car: accumulate, emit mean, advance pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ecg_acc <= '0;
      ecg_cnt <= '0;
      ecg_wr_ptr <= '0;
    end else if (bus.freeze) begin
      ecg_acc <= '0;
      ecg_cnt <= '0;
    end else if (ecg_take) begin
      if (ecg_last) begin
        ecg_acc <= '0;
        ecg_cnt <= '0;
        ecg_wr_ptr <= ecg_wr_ptr + 1'b1;
      end else begin
        ecg_acc <= ecg_sum;
        ecg_cnt <= ecg_cnt + 1'b1;
      end
    end
  end

  logic [ACW-1:0] emg_acc;
  logic [CW-1:0] emg_cnt;
  logic [TRACE_AW-1:0] emg_wr_ptr;
  logic emg_take;
  logic emg_last;
  logic emg_push;
  logic [ACW-1:0] emg_sum;

  assign emg_take = bus.emg_valid & run & ~bus.freeze;
  assign emg_last = (emg_cnt == CW'(N - 1));
  assign emg_push = emg_take & emg_last;
  assign emg_sum = emg_acc + ACW'(bus.emg_data);

  // EMG box-car: accumulate, emit mean, advance pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      emg_acc <= '0;
      emg_cnt <= '0;
      emg_wr_ptr <= '0;
    end else if (bus.freeze) begin
      emg_acc <= '0;
      emg_cnt <= '0;
    end else if (emg_take) begin
      if (emg_last) begin
        emg_acc <= '0;
        emg_cnt <= '0;
        emg_wr_ptr <= emg_wr_ptr + 1'b1;
      end else begin
        emg_acc <= emg_sum;
        emg_cnt <= emg_cnt + 1'b1;
      end
    end
  end

  logic ecg_hit;
  logic emg_hit;
  logic [TRACE_AW-1:0] ecg_raddr;
  logic [TRACE_AW-1:0] emg_raddr;
  logic [SAMPLE_W-1:0] ecg_rdata;
  logic [SAMPLE_W-1:0] emg_rdata;
  sel_e sel_d;
  sel_e sel_q;
  logic [SAMPLE_W-1:0] rd_mux;

  assign ecg_hit = win_hit(bus.sig_addr, ECG_BASE);
  assign emg_hit = win_hit(bus.sig_addr, EMG_BASE);
  assign ecg_raddr = ecg_wr_ptr
                   + win_idx(bus.sig_addr, ECG_BASE);
  assign emg_raddr = emg_wr_ptr
                   + win_idx(bus.sig_addr, EMG_BASE);

  // Window select; ECG wins when windows overlap.
  always_comb begin
    sel_d = SEL_NONE;
    priority case (1'b1)
      ecg_hit: sel_d = SEL_ECG;
      emg_hit: sel_d = SEL_EMG;
      default: sel_d = SEL_NONE;
    endcase
  end

  // Select follows the RAM read by one cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sel_q <= SEL_NONE;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Output mux over the registered RAM data.
  always_comb begin
    rd_mux = '0;
    unique case (sel_q)
      SEL_ECG: rd_mux = ecg_rdata;
      SEL_EMG: rd_mux = emg_rdata;
      default: rd_mux = '0;
    endcase
  end

  assign bus.sig_data = {20'b0, rd_mux};

  trace_ram u_ecg_ram (
    .clock (clock),
    .we    (clr_we | ecg_push),
    .waddr (clr_we ? clr_q : ecg_wr_ptr),
    .wdata (clr_we ? '0 : ecg_sum[ACW-1:DECIM_LOG2]),
    .raddr (ecg_raddr),
    .rdata (ecg_rdata)
  );

  trace_ram u_emg_ram (
    .clock (clock),
    .we    (clr_we | emg_push),
    .waddr (clr_we ? clr_q : emg_wr_ptr),
    .wdata (clr_we ? '0 : emg_sum[ACW-1:DECIM_LOG2]),
    .raddr (emg_raddr),
    .rdata (emg_rdata)
  );

endmodule

// File: tb/tb_sig_trace_buffer.sv
// Randomized bench for sig_trace_buffer with two
// instances (decimate by 4 and by 1) vs a scroll model.
module tb_sig_trace_buffer;

  localparam int EB = 'h801;
  localparam int MB = 'hC7F;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  sig_trace_buffer_if bus_a ();
  sig_trace_buffer_if bus_b ();

  sig_trace_buffer #(.DECIM_LOG2(2)) u_a (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus_a)
  );

  sig_trace_buffer #(.DECIM_LOG2(0)) u_b (
    .clock (clock),
    .reset (rst_n),
    .bus   (bus_b)
  );

  logic v [4];
  logic [11:0] d [4];
  logic frz [2];
  logic [11:0] addr [2];

  assign bus_a.ecg_valid = v[0];
  assign bus_a.ecg_data = d[0];
  assign bus_a.emg_valid = v[1];
  assign bus_a.emg_data = d[1];
  assign bus_a.freeze = frz[0];
  assign bus_a.sig_addr = addr[0];
  assign bus_b.ecg_valid = v[2];
  assign bus_b.ecg_data = d[2];
  assign bus_b.emg_valid = v[3];
  assign bus_b.emg_data = d[3];
  assign bus_b.freeze = frz[1];
  assign bus_b.sig_addr = addr[1];

  // Model: each trace is an oldest-first list of 512.
  int tr [4][512];
  int gsum [4];
  int gcnt [4];
  int nwr [4];
  int clr [2];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int rd_model(input int k,
                                  input logic [11:0] a);
    int ia;
    ia = int'(a);
    if (ia >= EB && ia < EB + 512) return tr[2*k][ia-EB];
    if (ia >= MB && ia < MB + 512) return tr[2*k+1][ia-MB];
    return 0;
  endfunction

  task automatic push(input int c, input int val);
    for (int i = 0; i < 511; i++) tr[c][i] = tr[c][i+1];
    tr[c][511] = val;
    nwr[c]++;
  endtask

  task automatic wipe(input int k);
    clr[k] = 0;
    for (int ch = 0; ch < 2; ch++) begin
      gsum[2*k+ch] = 0;
      gcnt[2*k+ch] = 0;
      nwr[2*k+ch] = 0;
      for (int i = 0; i < 512; i++) tr[2*k+ch][i] = 0;
    end
  endtask

  // One clock: predict, clock the DUTs and model, compare.
  task automatic step();
    int er [2];
    bit ok [2];
    bit rs;
    int n;
    int c;
    rs = rst_n;
    for (int k = 0; k < 2; k++) begin
      er[k] = rd_model(k, addr[k]);
      ok[k] = (clr[k] == 512);
    end
    chk("ready_a", 32'({bus_a.ecg_ready, bus_a.emg_ready}),
        ok[0] ? 32'd3 : 32'd0);
    chk("ready_b", 32'({bus_b.ecg_ready, bus_b.emg_ready}),
        ok[1] ? 32'd3 : 32'd0);
    @(posedge clock);
    for (int k = 0; k < 2; k++) begin
      n = (k == 0) ? 4 : 1;
      if (!rs) wipe(k);
      else if (clr[k] < 512) clr[k]++;
      else begin
        for (int ch = 0; ch < 2; ch++) begin
          c = 2 * k + ch;
          if (frz[k]) begin
            gsum[c] = 0;
            gcnt[c] = 0;
          end else if (v[c]) begin
            gsum[c] += int'(d[c]);
            gcnt[c]++;
            if (gcnt[c] == n) begin
              push(c, gsum[c] / n);
              gsum[c] = 0;
              gcnt[c] = 0;
            end
          end
        end
      end
    end
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      if (!rs) begin
        er[k] = 0;
        ok[k] = 1'b1;
      end
    end
    if (ok[0]) chk("rd_a", bus_a.sig_data, er[0]);
    if (ok[1]) chk("rd_b", bus_b.sig_data, er[1]);
  endtask

  task automatic feed(input int c, input int val);
    v[c] = 1'b1;
    d[c] = 12'(val);
    step();
    v[c] = 1'b0;
  endtask

  task automatic sweep();
    for (int i = 0; i < 512; i++) begin
      addr[0] = 12'(EB + i);
      addr[1] = 12'(MB + i);
      step();
      addr[0] = 12'(MB + i);
      addr[1] = 12'(EB + i);
      step();
    end
  endtask

  function automatic logic [11:0] rand_addr();
    case ($urandom_range(3))
      0: return 12'(EB + $urandom_range(511));
      1: return 12'(MB + $urandom_range(511));
      default: return 12'($urandom);
    endcase
  endfunction

  int p0;

  initial begin
    for (int c = 0; c < 4; c++) begin
      v[c] = 1'b0;
      d[c] = '0;
    end
    frz[0] = 1'b0;
    frz[1] = 1'b0;
    addr[0] = '0;
    addr[1] = '0;
    wipe(0);
    wipe(1);
    @(negedge clock);
    repeat (3) step();
    chk("rst_data_a", bus_a.sig_data, 0);
    chk("rst_rdy_a", 32'(bus_a.ecg_ready), 0);
    rst_n = 1'b1;

    repeat (511) step();
    chk("rdy_511", 32'(bus_a.ecg_ready), 0);
    step();
    chk("rdy_512", 32'(bus_a.ecg_ready), 1);
    chk("rdy_512_emg", 32'(bus_b.emg_ready), 1);
    sweep();

    addr[0] = 12'(EB + 511);
    feed(0, 100);
    feed(0, 200);
    feed(0, 300);
    feed(0, 401);
    step();
    chk("avg_250", bus_a.sig_data, 250);

    for (int i = 1; i <= 520; i++) feed(3, i);
    addr[1] = 12'(MB);
    step();
    chk("scroll_old", bus_b.sig_data, 9);
    addr[1] = 12'(MB + 511);
    step();
    chk("scroll_new", bus_b.sig_data, 520);
    chk("emg_ptr", 32'(u_b.emg_wr_ptr), 8);

    feed(0, 7);
    feed(0, 9);
    frz[0] = 1'b1;
    p0 = nwr[0] % 512;
    for (int i = 0; i < 10; i++) feed(0, $urandom_range(4095));
    chk("frz_ptr", 32'(u_a.ecg_wr_ptr), p0);
    frz[0] = 1'b0;
    for (int i = 0; i < 4; i++) feed(0, 40);
    chk("frz_ptr_after", 32'(u_a.ecg_wr_ptr), (p0 + 1) % 512);
    addr[0] = 12'(EB + 511);
    step();
    chk("frz_new", bus_a.sig_data, 40);
    addr[0] = 12'(EB + 510);
    step();
    chk("frz_prev", bus_a.sig_data, 250);

    addr[0] = 12'h800;
    addr[1] = 12'hA01;
    step();
    chk("dec_800", bus_a.sig_data, 0);
    chk("dec_a01_b", bus_b.sig_data, 0);
    addr[0] = 12'hA01;
    addr[1] = 12'h800;
    step();
    chk("dec_a01", bus_a.sig_data, 0);

    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < 4; c++) begin
        v[c] = 1'($urandom_range(1));
        d[c] = 12'($urandom);
      end
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(15) == 0) frz[k] = ~frz[k];
        addr[k] = rand_addr();
      end
      step();
    end
    for (int c = 0; c < 4; c++) v[c] = 1'b0;
    frz[0] = 1'b0;
    frz[1] = 1'b0;

    addr[1] = 12'(EB);
    p0 = tr[2][0];
    feed(2, (p0 + 1234) % 4096);
    chk("collide_old", bus_b.sig_data, p0);
    addr[1] = 12'(EB + 511);
    step();
    chk("collide_new", bus_b.sig_data, (p0 + 1234) % 4096);

    step();
    feed(0, 1000);
    feed(0, 2000);
    feed(0, 3000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_rdy", 32'(bus_a.ecg_ready), 0);
    repeat (512) step();
    sweep();
    addr[0] = 12'(EB + 511);
    for (int i = 0; i < 4; i++) feed(0, 8);
    step();
    chk("rst_lost_acc", bus_a.sig_data, 8);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/sig_trace_buffer.md
# sig_trace_buffer

Display-side sample store that sits directly upstream of the VGA controller. Accepts 12-bit ECG and EMG sample streams, box-car averages each by 2^DECIM_LOG2, and writes the results into two 512-entry circular trace memories. Serves the VGA controller's 12-bit `sig_addr` / 32-bit `sig_data` read port so that logical index 0 is the oldest point and 511 the newest, giving a left-scrolling trace.

## Interface
- `DECIM_LOG2`, 2: log2 of the averaging/decimation factor; range 0..4.
- `ECG_BASE`, 12'h801: first read address of the ECG window; 512 consecutive addresses.
- `EMG_BASE`, 12'hC7F: first read address of the EMG window; 512 consecutive addresses.
- `clock  in  1`: single system clock; all logic is on its rising edge.
- `reset  in  1`: synchronous, active-low reset.
- `ecg_valid  in  1`: ECG sample strobe.
- `ecg_data  in  12`: ECG sample, unsigned.
- `ecg_ready  out  1`: ECG sample is accepted when `ecg_valid && ecg_ready`.
- `emg_valid  in  1`, `emg_data  in  12`, `emg_ready  out  1`: EMG stream, same rules as the ECG stream.
- `freeze  in  1`: while high, accepted samples are discarded and the trace is held.
- `sig_addr  in  12`: read address from the VGA controller.
- `sig_data  out  32`: `{20'b0, sample[11:0]}`, registered.

## Operation
- FSM states:
  - CLEAR: entered on reset. A 9-bit clear counter runs 0..511 and writes 0 to the same index in both RAMs. Exits to RUN after index 511 is written, so CLEAR lasts 512 cycles.
  - RUN: normal operation.
- Ready outputs: `ecg_ready`/`emg_ready` are 0 in CLEAR and 1 in RUN, so there is no backpressure in RUN.
- Per-channel averaging:
  - Accumulator width is 12+DECIM_LOG2 bits. Sample counter width is DECIM_LOG2 bits.
  - Each accepted sample is added to the accumulator.
  - On the 2^DECIM_LOG2-th accepted sample, the block writes `(acc + sample) >> DECIM_LOG2` (truncate) to `ram[wr_ptr]`, increments `wr_ptr` modulo 512, and clears the accumulator and counter in the same cycle.
  - DECIM_LOG2=0: every accepted sample is written directly.
- `wr_ptr` (9-bit, per channel): points to the oldest entry, which is the next slot to be written. It wraps 511→0 with no flag.
- Freeze:
  - While `freeze`=1, accepted samples are dropped and `wr_ptr` holds.
  - On the rising edge of `freeze`, the partial accumulator and counter are cleared.
  - After `freeze` falls, averaging restarts from an empty accumulator.
- Read decode, evaluated on each cycle's `sig_addr`:
  - ECG hit when `ECG_BASE <= sig_addr < ECG_BASE+512`. Logical index is `i = sig_addr-ECG_BASE`, physical index is `(ecg_wr_ptr + i) mod 512`.
  - EMG hit uses the same rule with `EMG_BASE` and `emg_wr_ptr`.
  - Any other address returns 0.
  - If both windows match (overlapping parameters), ECG wins.
- Read/write collision: a read and a write to the same physical entry in the same cycle returns the old data (read-before-write). The pointer used for translation is the value before that cycle's increment.
- The ECG and EMG channels are fully independent and may write in the same cycle.
- Reset asserted mid-operation: the block re-enters CLEAR the next cycle, and any in-flight accumulation is lost.

## Timing
- Reset values:
  - `ecg_ready`=0, `emg_ready`=0, `sig_data`=0.
  - Pointers, accumulators and counters are 0. The state is CLEAR.
- Ready rise: `ecg_ready`/`emg_ready` go high on the first cycle after the 512th clear write, i.e. 513 cycles after reset deasserts.
- Read latency: `sig_data` is valid 1 clock after `sig_addr` is presented. The read is fully pipelined, one address per cycle.
- Write latency: a completed average is visible to a read issued 1 cycle after the final accepted sample of the group. Its logical index is 511, since the pointer has already advanced.
- The VGA controller samples on a divided clock (÷4) that is slower than `clock`, so 1-cycle latency meets its needs. No clock-domain crossing exists.

## Structure
- Shared package `sig_buf_pkg` holds:
  - `TRACE_DEPTH`=512 and `TRACE_AW`=9;
  - `SAMPLE_W`=12;
  - the default `ECG_BASE`/`EMG_BASE` constants, shared with the VGA controller;
  - the FSM state enum {CLEAR, RUN}.
- Sub-module `trace_ram`: a 512×12 simple dual-port RAM with one write port, one registered read port and read-before-write behaviour, instantiated once per channel.
- The averaging datapath is small and is written inline per channel in the top level (not a separate sub-module).

## Test plan
- Clear after reset:
  - Stimulus: deassert reset, then read ECG_BASE..ECG_BASE+511 after 513 cycles.
  - Required response: all reads return 0, and `ecg_ready` rises on exactly cycle 513.
- Averaging, DECIM_LOG2=2:
  - Stimulus: feed ECG samples 100, 200, 300, 401.
  - Required response: address ECG_BASE+511 reads 250, which is 1001>>2 truncated.
- Scroll order:
  - Stimulus: with DECIM_LOG2=0, write EMG samples 1..520.
  - Required response: address EMG_BASE reads 9, EMG_BASE+511 reads 520, and `emg_wr_ptr` = 8.
- Freeze:
  - Stimulus: feed 2 ECG samples, raise `freeze`, feed 10 samples, drop `freeze`, feed 4 samples of value 40.
  - Required response: exactly one new entry of value 40 is written, and no writes occur during the freeze.
- Read decode and collision:
  - Stimulus: read 12'h800 and 12'hA01; separately, read index 0 in the same cycle its entry is overwritten.
  - Required response: 12'h800 and 12'hA01 both return 0, and the collision read returns the old value.
- Reset mid-stream:
  - Stimulus: assert reset after 3 of 4 samples of a group.
  - Required response: `ready` drops the next cycle and all entries read 0 after re-clear.
